// File: rtl/trace_checker_if.sv
// Handshake bundle between a trace_checker and whatever loads and samples it; 0-cycle wiring.
// Backpressure: load_ready from the checker gates load_valid; sample/start have no backpressure.
interface trace_checker_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 3,
  parameter int IDX_W  = 7,
  parameter int ERR_W  = 16
);
  logic                     load_valid;
  logic                     load_ready;
  logic [NUM_CH*DATA_W-1:0] load_data;
  logic                     load_skip;
  logic                     start;
  logic                     sample;
  logic [NUM_CH*DATA_W-1:0] obs_data;
  logic                     busy;
  logic                     done;
  logic                     pass;
  logic [ERR_W-1:0]         err_count;
  logic [IDX_W-1:0]         first_err_idx;
  logic [NUM_CH-1:0]        first_err_mask;

  modport master (
    output load_valid, load_data, load_skip, start, sample, obs_data,
    input  load_ready, busy, done, pass, err_count, first_err_idx, first_err_mask
  );

  modport slave (
    input  load_valid, load_data, load_skip, start, sample, obs_data,
    output load_ready, busy, done, pass, err_count, first_err_idx, first_err_mask
  );
endinterface

// File: rtl/trace_checker.sv
// Expected-vector FIFO compared against obs_data on each sample; TRACE_CHK_STOP_ON_ERR_EN ends a run at first mismatch.
// Latency: err_count/first_err_* and done/pass update the cycle after the sample edge.
// Backpressure: load_ready low in RUN or when the FIFO is full; sample is never stalled.
module trace_checker #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 3,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 7,
  parameter int ERR_W  = 16
) (
  input logic            clock,
  input logic            reset,
  trace_checker_if.slave tc
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int VW    = NUM_CH * DATA_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [VW:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [IDX_W-1:0]  count, run_idx;
  logic [ERR_W-1:0]  err_q;
  logic [IDX_W-1:0]  first_idx_q;
  logic [NUM_CH-1:0] first_mask_q;
  logic [VW:0]       head;
  logic [NUM_CH-1:0] mask;
  logic              push, pop, go, flush, ready;

  assign head  = mem[rd_ptr];
  assign ready = (state_q != RUN) && (count < IDX_W'(DEPTH));
  assign push  = tc.load_valid && ready;
  assign pop   = tc.sample && (state_q == RUN);
  // start is judged on the count before any same-cycle push
  assign go    = tc.start && (state_q != RUN) && (count != '0);

  always_comb begin
    mask = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      mask[c] = !head[VW] && (head[c*DATA_W +: DATA_W] != tc.obs_data[c*DATA_W +: DATA_W]);
    end
  end

`ifdef TRACE_CHK_STOP_ON_ERR_EN
  assign flush = pop && (mask != '0);
`else
  assign flush = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (go) state_d = RUN;
      RUN:        if (pop && ((count == IDX_W'(1)) || flush)) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {tc.load_skip, tc.load_data};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (flush)     count <= '0;
      else if (push) count <= count + IDX_W'(1);
      else if (pop)  count <= count - IDX_W'(1);
    end
  end

  // err_q only ever returns to zero on a new run, so zero means "no failure latched yet"
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q        <= '0;
      first_idx_q  <= '0;
      first_mask_q <= '0;
      run_idx      <= '0;
    end else if (go) begin
      err_q        <= '0;
      first_idx_q  <= '0;
      first_mask_q <= '0;
      run_idx      <= '0;
    end else if (pop) begin
      run_idx <= run_idx + IDX_W'(1);
      if (mask != '0) begin
        if (err_q != '1) err_q <= err_q + ERR_W'(1);
        if (err_q == '0) begin
          first_idx_q  <= run_idx;
          first_mask_q <= mask;
        end
      end
    end
  end

  assign tc.load_ready     = ready;
  assign tc.busy           = (state_q == RUN);
  assign tc.done           = (state_q == DONE);
  assign tc.pass           = (state_q == DONE) && (err_q == '0);
  assign tc.err_count      = err_q;
  assign tc.first_err_idx  = first_idx_q;
  assign tc.first_err_mask = first_mask_q;
endmodule

// File: tb/tb_trace_checker.sv
// Random and directed stimulus for trace_checker, checked every cycle against a queue-based model.
module tb_trace_checker;
  localparam int DATA_W = 32;
  localparam int NUM_CH = 3;
  localparam int DEPTH  = 64;
  localparam int IDX_W  = 7;
  localparam int ERR_W  = 16;
  localparam int VW     = NUM_CH * DATA_W;
`ifdef TRACE_CHK_STOP_ON_ERR_EN
  localparam int T3_ERR = 1;
`else
  localparam int T3_ERR = 2;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  trace_checker_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .IDX_W(IDX_W), .ERR_W(ERR_W)) tc ();

  trace_checker #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .IDX_W(IDX_W), .ERR_W(ERR_W)) dut (
    .clock (clock),
    .reset (reset),
    .tc    (tc.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: queue of {skip, vector}, run flags and the reported results
  logic [VW:0]       m_q[$];
  bit                m_run, m_done, m_have;
  int                m_err, m_fidx, m_idx;
  logic [NUM_CH-1:0] m_fmask;

  function automatic logic [VW-1:0] vec(input logic [31:0] c0, input logic [31:0] c1, input logic [31:0] c2);
    return {c2, c1, c0};
  endfunction

  task automatic model_edge();
    logic [VW:0]       e;
    logic [NUM_CH-1:0] mm;
    bit                rdy, go;
    if (reset) begin
      m_q.delete();
      m_run = 0; m_done = 0; m_have = 0;
      m_err = 0; m_fidx = 0; m_idx = 0; m_fmask = '0;
    end else begin
      rdy = !m_run && (m_q.size() < DEPTH);
      go  = tc.start && !m_run && (m_q.size() > 0);
      if (m_run && tc.sample) begin
        e  = m_q.pop_front();
        mm = '0;
        if (!e[VW]) begin
          for (int c = 0; c < NUM_CH; c++)
            mm[c] = (e[c*DATA_W +: DATA_W] != tc.obs_data[c*DATA_W +: DATA_W]);
        end
        if (mm != '0) begin
          if (m_err < (1 << ERR_W) - 1) m_err++;
          if (!m_have) begin
            m_have = 1; m_fidx = m_idx; m_fmask = mm;
          end
`ifdef TRACE_CHK_STOP_ON_ERR_EN
          m_q.delete();
`endif
        end
        m_idx++;
        if (m_q.size() == 0) begin
          m_run = 0; m_done = 1;
        end
      end
      if (tc.load_valid && rdy) m_q.push_back({tc.load_skip, tc.load_data});
      if (go) begin
        m_run = 1; m_done = 0; m_have = 0;
        m_err = 0; m_fidx = 0; m_idx = 0; m_fmask = '0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("load_ready", tc.load_ready, !m_run && (m_q.size() < DEPTH));
    chk("busy", tc.busy, m_run);
    chk("done", tc.done, m_done);
    chk("pass", tc.pass, m_done && (m_err == 0));
    chk("err_count", tc.err_count, m_err);
    chk("first_err_idx", tc.first_err_idx, m_fidx);
    chk("first_err_mask", tc.first_err_mask, m_fmask);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
    tc.load_valid = 1'b0;
    tc.load_skip  = 1'b0;
    tc.start      = 1'b0;
    tc.sample     = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [VW-1:0] d, input logic skip);
    tc.load_valid = 1'b1;
    tc.load_data  = d;
    tc.load_skip  = skip;
    step();
  endtask

  task automatic do_start();
    tc.start = 1'b1;
    step();
  endtask

  task automatic do_sample(input logic [VW-1:0] obs);
    tc.sample   = 1'b1;
    tc.obs_data = obs;
    step();
  endtask

  task automatic sample_match();
    logic [VW:0] e;
    e = (m_q.size() > 0) ? m_q[0] : '0;
    do_sample(e[VW-1:0]);
  endtask

  initial begin
    logic [VW:0]   e;
    logic [VW-1:0] obs;
    int            r;
    reset         = 1'b1;
    tc.load_valid = 1'b0;
    tc.load_data  = '0;
    tc.load_skip  = 1'b0;
    tc.start      = 1'b0;
    tc.sample     = 1'b0;
    tc.obs_data   = '0;

    // 1: reset values, then start on empty FIFO stays IDLE
    do_reset(2);
    chk("t1_ready", tc.load_ready, 1);
    chk("t1_busy", tc.busy, 0);
    chk("t1_err", tc.err_count, 0);
    do_start();
    chk("t1_empty_start", tc.busy, 0);

    // 2: three matching vectors
    do_load(vec(5, 0, 5), 0);
    do_load(vec(3, 0, 3), 0);
    do_load(vec(8, 5, 3), 0);
    do_start();
    chk("t2_busy", tc.busy, 1);
    do_sample(vec(5, 0, 5));
    do_sample(vec(3, 0, 3));
    chk("t2_not_done", tc.done, 0);
    do_sample(vec(8, 5, 3));
    chk("t2_done", tc.done, 1);
    chk("t2_pass", tc.pass, 1);

    // 3: ch1 wrong at idx1, all channels wrong at idx3
    do_load(vec(1, 2, 3), 0);
    do_load(vec(32'h10, 5, 7), 0);
    do_load(vec(9, 9, 9), 0);
    do_load(vec(32'hA, 32'hB, 32'hC), 0);
    do_start();
    do_sample(vec(1, 2, 3));
    do_sample(vec(32'h10, 4, 7));
    do_sample(vec(9, 9, 9));
    do_sample(vec(32'hB, 32'hA, 32'hD));
    chk("t3_err", tc.err_count, T3_ERR);
    chk("t3_idx", tc.first_err_idx, 1);
    chk("t3_mask", tc.first_err_mask, 3'b010);
    chk("t3_pass", tc.pass, 0);

    // 4: skip slot swallows garbage; start on the now-empty FIFO does nothing
    do_load({$urandom, $urandom, $urandom}, 1);
    do_load(vec(0, 0, 32768), 0);
    do_start();
    do_sample({$urandom, $urandom, $urandom});
    do_sample(vec(0, 0, 32768));
    chk("t4_pass", tc.pass, 1);
    do_start();
    chk("t4_empty_start", tc.busy, 0);

    // 5: fill to DEPTH, overflow dropped, drain with matches
    for (int i = 0; i < DEPTH + 1; i++) do_load({$urandom, $urandom, $urandom}, 1'($urandom_range(0, 7) == 0));
    chk("t5_full", tc.load_ready, 0);
    do_start();
    for (int i = 0; i < DEPTH; i++) sample_match();
    chk("t5_done", tc.done, 1);
    chk("t5_pass", tc.pass, 1);
    chk("t5_ready", tc.load_ready, 1);

    // 6: reset mid-run
    for (int i = 0; i < 5; i++) do_load({$urandom, $urandom, $urandom}, 0);
    do_start();
    sample_match();
    sample_match();
    do_reset(1);
    chk("t6_busy", tc.busy, 0);
    do_start();
    chk("t6_empty", tc.busy, 0);

    // 6b: mismatch at idx0
    for (int i = 0; i < 3; i++) do_load(vec(i, i + 1, i + 2), 0);
    do_start();
    do_sample(vec(7, 7, 7));
    chk("t6b_err", tc.err_count, 1);
    chk("t6b_mask", tc.first_err_mask, 3'b111);
`ifdef TRACE_CHK_STOP_ON_ERR_EN
    chk("t6b_done", tc.done, 1);
    chk("t6b_flushed", tc.load_ready, 1);
`endif
    do_reset(1);

    // random traffic, including simultaneous start/load/sample and resets
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset(1);
      end else begin
        tc.load_valid = ($urandom_range(0, 99) < 40);
        tc.load_data  = {$urandom, $urandom, $urandom};
        tc.load_skip  = ($urandom_range(0, 99) < 15);
        tc.start      = ($urandom_range(0, 99) < 8);
        tc.sample     = ($urandom_range(0, 99) < 50);
        e   = (m_q.size() > 0) ? m_q[0] : '0;
        obs = e[VW-1:0];
        if ($urandom_range(0, 99) < 15) obs[$urandom_range(0, VW - 1)] ^= 1'b1;
        if ($urandom_range(0, 99) < 3)  obs = {$urandom, $urandom, $urandom};
        tc.obs_data = obs;
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
